// File: rtl/loopback_pattern_gen.sv
// Initiator side of the delayed-compare loopback check.
// Generates a counter or LFSR word stream onto dut_data/ref_data, then samples
// the comparator's equal result LATENCY cycles after each word and counts
// mismatches. A run ends with a one-cycle done pulse plus pass/err_count.
module loopback_pattern_gen #(
  parameter int unsigned        LENGTH  = 8,
  parameter int unsigned        LATENCY = 3,
  parameter int unsigned        COUNT_W = 16,
  parameter logic [LENGTH-1:0]  SEED    = 8'hA5,
  parameter logic [LENGTH-1:0]  POLY    = 8'hB8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [COUNT_W-1:0] num_words,
  input  logic               inject_err,
  input  logic               equal_in,
  output logic [LENGTH-1:0]  dut_data,
  output logic [LENGTH-1:0]  ref_data,
  output logic               data_valid,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [COUNT_W-1:0] err_count
);

  localparam int unsigned        DW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LENGTH-1:0]  ONE_L    = LENGTH'(1);
  localparam logic [COUNT_W-1:0] ONE_C    = COUNT_W'(1);
  localparam logic [LENGTH-1:0]  SEED_EFF = (SEED == '0) ? ONE_L : SEED;
  localparam logic [DW-1:0]      DRAIN_LD = DW'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state;
  logic               mode_r;
  logic [COUNT_W-1:0] remaining;
  logic [LENGTH-1:0]  pat;
  logic [DW-1:0]      drain_cnt;
  logic [LATENCY-1:0] vshift;

  logic [LENGTH-1:0]  lfsr_nxt;
  logic [LENGTH-1:0]  pat_nxt;
  logic               err_hit;
  logic [COUNT_W-1:0] err_count_nxt;

  // Next pattern word and the error count including this cycle's check.
  always_comb begin
    lfsr_nxt = pat >> 1;
    if (pat[0]) lfsr_nxt = lfsr_nxt ^ POLY;
    pat_nxt = mode_r ? lfsr_nxt : (pat + ONE_L);
    err_hit = vshift[LATENCY-1] & ~equal_in & (err_count != '1);
    err_count_nxt = err_hit ? (err_count + ONE_C) : err_count;
  end

  // Validity pipeline: bit LATENCY-1 marks the cycle a word's compare result arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      vshift <= '0;
    end else begin
      vshift[0] <= data_valid;
      for (int unsigned i = 1; i < LATENCY; i++) vshift[i] <= vshift[i-1];
    end
  end

  // Control FSM with registered outputs.
  // Outputs are registered, so inject_err sampled on an edge in RUN corrupts
  // the word loaded at that edge (the word driven in the following cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      mode_r     <= 1'b0;
      remaining  <= '0;
      pat        <= '0;
      drain_cnt  <= '0;
      dut_data   <= '0;
      ref_data   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
    end else begin
      err_count <= err_count_nxt;
      done      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mode_r    <= mode;
            remaining <= num_words;
            err_count <= '0;
            pass      <= 1'b0;
            if (num_words == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
              pat   <= '0;
            end else begin
              state      <= S_RUN;
              busy       <= 1'b1;
              data_valid <= 1'b1;
              pat        <= mode ? SEED_EFF : '0;
              dut_data   <= mode ? SEED_EFF : '0;
              ref_data   <= mode ? SEED_EFF : '0;
            end
          end
        end
        S_RUN: begin
          if (remaining == ONE_C) begin
            state      <= S_DRAIN;
            data_valid <= 1'b0;
            dut_data   <= '0;
            ref_data   <= '0;
            drain_cnt  <= DRAIN_LD;
          end else begin
            remaining <= remaining - ONE_C;
            pat       <= pat_nxt;
            ref_data  <= pat_nxt;
            dut_data  <= pat_nxt ^ (inject_err ? ONE_L : '0);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count_nxt == '0);
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_loopback_pattern_gen.sv
// Directed bench: the datapath is an ideal 3-stage register chain on both
// dut_data and ref_data, and the comparator compares the chain outputs.
module tb_loopback_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [15:0] num_words;
  logic        inject_err;
  logic        equal_in;
  logic [7:0]  dut_data;
  logic [7:0]  ref_data;
  logic        data_valid;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] d1, d2, d3, r1, r2, r3;

  always #5 clk = ~clk;

  loopback_pattern_gen #(
    .LENGTH(8), .LATENCY(3), .COUNT_W(16), .SEED(8'hA5), .POLY(8'hB8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .num_words(num_words),
    .inject_err(inject_err), .equal_in(equal_in), .dut_data(dut_data),
    .ref_data(ref_data), .data_valid(data_valid), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count)
  );

  // Ideal fixed-latency datapath plus comparator.
  always_ff @(posedge clk) begin
    d1 <= dut_data; d2 <= d1; d3 <= d2;
    r1 <= ref_data; r2 <= r1; r3 <= r2;
  end
  assign equal_in = (d3 == r3);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic m, input logic [15:0] n);
    start = 1'b1; mode = m; num_words = n;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; num_words = '0; inject_err = 1'b0;
    tick(); tick();
    chk("rst_dut_data", 32'(dut_data), 0);
    chk("rst_ref_data", 32'(ref_data), 0);
    chk("rst_valid", 32'(data_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err", 32'(err_count), 0);
    rst = 1'b0;
    tick();

    // 1: counter, N=4 -> words in cycles 1..4, drain 5..7, done at 8
    kick(1'b0, 16'd4);
    chk("t1_c1_dut", 32'(dut_data), 0);
    chk("t1_c1_valid", 32'(data_valid), 1);
    chk("t1_c1_busy", 32'(busy), 1);
    tick(); chk("t1_c2_dut", 32'(dut_data), 1);
    tick(); chk("t1_c3_dut", 32'(dut_data), 2);
    tick(); chk("t1_c4_dut", 32'(dut_data), 3);
    chk("t1_c4_ref", 32'(ref_data), 3);
    tick(); chk("t1_c5_valid", 32'(data_valid), 0);
    chk("t1_c5_dut", 32'(dut_data), 0);
    chk("t1_c5_busy", 32'(busy), 1);
    tick(); tick(); chk("t1_c7_done", 32'(done), 0);
    tick(); chk("t1_c8_done", 32'(done), 1);
    chk("t1_c8_busy", 32'(busy), 0);
    chk("t1_c8_pass", 32'(pass), 1);
    chk("t1_c8_err", 32'(err_count), 0);
    tick(); chk("t1_c9_done", 32'(done), 0);
    chk("t1_c9_pass_held", 32'(pass), 1);

    // 2: LFSR, N=4 -> A5 EA 75 82
    kick(1'b1, 16'd4);
    chk("t2_c1_ref", 32'(ref_data), 32'hA5);
    chk("t2_c1_pass_clr", 32'(pass), 0);
    tick(); chk("t2_c2_ref", 32'(ref_data), 32'hEA);
    tick(); chk("t2_c3_ref", 32'(ref_data), 32'h75);
    tick(); chk("t2_c4_ref", 32'(ref_data), 32'h82);
    chk("t2_c4_dut", 32'(dut_data), 32'h82);
    tick(); tick(); tick(); tick();
    chk("t2_c8_done", 32'(done), 1);
    chk("t2_c8_pass", 32'(pass), 1);
    tick();

    // 3: inject_err raised in cycle 2 corrupts the 3rd word (cycle 3)
    kick(1'b0, 16'd4);
    tick(); inject_err = 1'b1;
    tick(); inject_err = 1'b0;
    chk("t3_c3_dut", 32'(dut_data), 3);
    chk("t3_c3_ref", 32'(ref_data), 2);
    tick(); chk("t3_c4_dut", 32'(dut_data), 3);
    tick(); tick(); chk("t3_c6_err", 32'(err_count), 0);
    tick(); chk("t3_c7_err", 32'(err_count), 1);
    tick(); chk("t3_c8_done", 32'(done), 1);
    chk("t3_c8_err", 32'(err_count), 1);
    chk("t3_c8_pass", 32'(pass), 0);
    tick(); inject_err = 1'b1;
    tick(); inject_err = 1'b0;
    chk("t3_idle_inject_ignored", 32'(err_count), 1);

    // 4: N=0 -> done in cycle 1, no data_valid
    kick(1'b0, 16'd0);
    chk("t4_c1_done", 32'(done), 1);
    chk("t4_c1_valid", 32'(data_valid), 0);
    chk("t4_c1_busy", 32'(busy), 0);
    chk("t4_c1_pass", 32'(pass), 1);
    chk("t4_c1_err", 32'(err_count), 0);
    tick(); chk("t4_c2_done", 32'(done), 0);

    // 5: counter wrap, N=260, done at 264
    kick(1'b0, 16'd260);
    for (int c = 2; c <= 264; c++) begin
      tick();
      if (c == 256) chk("t5_c256_ref", 32'(ref_data), 32'hFF);
      if (c == 257) chk("t5_c257_ref", 32'(ref_data), 32'h00);
      if (c == 260) chk("t5_c260_valid", 32'(data_valid), 1);
      if (c == 261) chk("t5_c261_valid", 32'(data_valid), 0);
      if (c == 263) chk("t5_c263_done", 32'(done), 0);
    end
    chk("t5_c264_done", 32'(done), 1);
    chk("t5_c264_pass", 32'(pass), 1);
    chk("t5_c264_err", 32'(err_count), 0);
    tick();

    // 6: reset mid-run, then start ignored while busy
    kick(1'b0, 16'd10);
    tick(); tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("t6_rst_dut", 32'(dut_data), 0);
    chk("t6_rst_valid", 32'(data_valid), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_done", 32'(done), 0);
    tick(); chk("t6_post_rst_done", 32'(done), 0);
    chk("t6_post_rst_busy", 32'(busy), 0);
    kick(1'b0, 16'd5);
    tick(); start = 1'b1; mode = 1'b1; num_words = 16'd2;
    tick(); start = 1'b0;
    chk("t6_c3_dut", 32'(dut_data), 2);
    tick(); tick(); chk("t6_c5_dut", 32'(dut_data), 4);
    chk("t6_c5_valid", 32'(data_valid), 1);
    tick(); chk("t6_c6_valid", 32'(data_valid), 0);
    tick(); tick(); chk("t6_c8_done", 32'(done), 0);
    tick(); chk("t6_c9_done", 32'(done), 1);
    chk("t6_c9_pass", 32'(pass), 1);
    tick(); chk("t6_c10_done", 32'(done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
